// File: rtl/mbox_req_arb.sv
// MBOX requester arbiter: grants one requester per cycle, with a one-cycle recovery gap and a grant timeout.
// Define MBOX_ARB_RR_EN for round-robin arbitration; when it is undefined, the lowest-index request wins.
module mbox_req_arb #(
  parameter int N_REQ = 4,
  parameter int TMO_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic                     done,
  input  logic [TMO_W-1:0]         tmo_limit,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     busy,
  output logic                     tmo_err
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, GRANT, RECOVER} state_t;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [IDX_W-1:0] grant_idx_nxt;
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  logic             tmo_err_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             tmo_hit;

`ifdef MBOX_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;

  // Search starts one past the previous winner and wraps around.
  always_comb begin
    int k;
    logic [IDX_W-1:0] cand;
    win_vld = 1'b0;
    win_idx = '0;
    k       = 0;
    cand    = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      k    = (int'(rr_ptr) + off) % N_REQ;
      cand = IDX_W'(k);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end
`endif

  // A zero limit disables the timeout; the limit is compared live, so a change applies at once.
  assign tmo_hit = (tmo_limit != '0) && (tmo_cnt == tmo_limit);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    grant_idx_nxt = grant_idx;
    tmo_err_nxt   = 1'b0;
    tmo_cnt_nxt   = tmo_cnt;
`ifdef MBOX_ARB_RR_EN
    rr_ptr_nxt    = rr_ptr;
`endif
    unique case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt          = GRANT;
          grant_nxt          = '0;
          grant_nxt[win_idx] = 1'b1;
          grant_idx_nxt      = win_idx;
          tmo_cnt_nxt        = '0;
`ifdef MBOX_ARB_RR_EN
          rr_ptr_nxt         = win_idx;
`endif
        end
      end
      GRANT: begin
        if (!done && (tmo_cnt != '1)) begin
          tmo_cnt_nxt = tmo_cnt + 1'b1;
        end
        // done takes precedence over a timeout in the same cycle.
        if (done) begin
          state_nxt = RECOVER;
          grant_nxt = '0;
        end else if (tmo_hit) begin
          state_nxt   = RECOVER;
          grant_nxt   = '0;
          tmo_err_nxt = 1'b1;
        end
      end
      RECOVER: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      tmo_err   <= 1'b0;
      tmo_cnt   <= '0;
`ifdef MBOX_ARB_RR_EN
      rr_ptr    <= IDX_W'(N_REQ - 1);
`endif
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      grant_idx <= grant_idx_nxt;
      tmo_err   <= tmo_err_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
`ifdef MBOX_ARB_RR_EN
      rr_ptr    <= rr_ptr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mbox_req_arb.sv
// Scoreboard bench for mbox_req_arb: directed stimulus queues expected grant/timeout events,
// and a negedge monitor pops and compares them, including the edge number at which they appear.
`timescale 1ns/1ps
module tb_mbox_req_arb;

  localparam int N_REQ = 4;
  localparam int TMO_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_REQ-1:0] req;
  logic             done;
  logic [TMO_W-1:0] tmo_limit;
  logic [N_REQ-1:0] grant;
  logic [1:0]       grant_idx;
  logic             busy;
  logic             tmo_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    bit         is_tmo;
    logic [3:0] grant;
    logic [1:0] idx;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  mbox_req_arb #(.N_REQ(N_REQ), .TMO_W(TMO_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .tmo_limit (tmo_limit),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .tmo_err   (tmo_err)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge number k, cyc holds k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic applyStimulus(input logic [3:0] r, input logic d, input logic [7:0] lim);
    req       = r;
    done      = d;
    tmo_limit = lim;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expectGrant(input int idx, input int at);
    exp_t e;
    e.is_tmo = 1'b0;
    e.grant  = 4'(1 << idx);
    e.idx    = 2'(idx);
    e.cyc    = at;
    exp_q.push_back(e);
  endtask

  task automatic expectTmo(input int idx, input int at);
    exp_t e;
    e.is_tmo = 1'b1;
    e.grant  = '0;
    e.idx    = 2'(idx);
    e.cyc    = at;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] g, input logic [1:0] idx,
                             input logic b, input logic t);
    n_checks++;
    if (grant !== g || grant_idx !== idx || busy !== b || tmo_err !== t) begin
      n_fail++;
      $display("[TB] FAIL %s: got grant=%b idx=%0d busy=%b tmo_err=%b, expected grant=%b idx=%0d busy=%b tmo_err=%b",
               name, grant, grant_idx, busy, tmo_err, g, idx, b, t);
    end
  endtask

  task automatic popCheck(input bit is_tmo);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL unexpected_event: got kind=%0d grant=%b idx=%0d at edge %0d, expected no event",
               is_tmo, grant, grant_idx, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.is_tmo != is_tmo || grant !== e.grant || grant_idx !== e.idx || cyc != e.cyc) begin
        n_fail++;
        $display("[TB] FAIL %s: got kind=%0d grant=%b idx=%0d edge=%0d, expected kind=%0d grant=%b idx=%0d edge=%0d",
                 e.is_tmo ? "tmo_event" : "grant_event", is_tmo, grant, grant_idx, cyc,
                 e.is_tmo, e.grant, e.idx, e.cyc);
      end
    end
  endtask

  // Monitor: a new grant or a tmo_err pulse is an event; a live grant must never change value.
  logic [N_REQ-1:0] prev_grant = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_grant = '0;
    end else begin
      if (prev_grant != '0) begin
        n_checks++;
        if (grant != '0 && grant != prev_grant) begin
          n_fail++;
          $display("[TB] FAIL grant_hold: got grant=%b, expected %b or 0", grant, prev_grant);
        end
      end
      if (grant != '0 && prev_grant == '0) popCheck(1'b0);
      if (tmo_err) popCheck(1'b1);
      prev_grant = grant;
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c, g;
    int         exp_order [5];
    int         tbl_exp   [4];
    logic [3:0] tbl_req   [4];
    tbl_req = '{4'b1100, 4'b0111, 4'b1110, 4'b1001};
`ifdef MBOX_ARB_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
    tbl_exp   = '{2, 0, 1, 3};
`else
    exp_order = '{0, 0, 0, 0, 0};
    tbl_exp   = '{2, 0, 1, 0};
`endif

    applyStimulus('0, 1'b0, '0);
    rst_n = 1'b0;
    tick(2);
    checkOutput("reset_values", '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    checkOutput("idle_no_req", '0, '0, 1'b0, 1'b0);

    // All requesting, done held high: one grant every 3 edges; done in IDLE/RECOVER is ignored.
    c = cyc;
    applyStimulus(4'b1111, 1'b1, '0);
    for (int i = 0; i < 5; i++) expectGrant(exp_order[i], c + 1 + 3 * i);
    tick(13);
    applyStimulus('0, 1'b1, '0);
    tick(1);
    checkOutput("order_recover", '0, 2'(exp_order[4]), 1'b1, 1'b0);
    applyStimulus('0, 1'b0, '0);
    tick(1);
    checkOutput("order_idle", '0, 2'(exp_order[4]), 1'b0, 1'b0);

    // Basic grant, held against req changes, then done -> RECOVER -> IDLE -> new grant.
    c = cyc;
    applyStimulus(4'b1010, 1'b0, '0);
    expectGrant(1, c + 1);
    tick(1);
    checkOutput("grant_1010", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b0001, 1'b0, '0);
    tick(2);
    checkOutput("grant_held", 4'b0010, 2'd1, 1'b1, 1'b0);
    c = cyc;
    applyStimulus(4'b1000, 1'b1, '0);
    expectGrant(3, c + 3);
    tick(1);
    applyStimulus(4'b1000, 1'b0, '0);
    checkOutput("recover", '0, 2'd1, 1'b1, 1'b0);
    tick(1);
    checkOutput("idle_after_recover", '0, 2'd1, 1'b0, 1'b0);
    tick(1);
    checkOutput("regrant_1000", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Timeout with limit 5 fires 6 edges after the grant edge.
    g = cyc;
    applyStimulus('0, 1'b0, 8'd5);
    expectTmo(3, g + 6);
    tick(5);
    checkOutput("pre_timeout", 4'b1000, 2'd3, 1'b1, 1'b0);
    tick(1);
    checkOutput("timeout_edge", '0, 2'd3, 1'b1, 1'b1);
    tick(1);
    checkOutput("after_timeout", '0, 2'd3, 1'b0, 1'b0);

    // done coincides with counter == limit: no tmo_err.
    c = cyc;
    applyStimulus(4'b0100, 1'b0, 8'd5);
    expectGrant(2, c + 1);
    tick(1);
    applyStimulus('0, 1'b0, 8'd5);
    tick(5);
    applyStimulus('0, 1'b1, 8'd5);
    tick(1);
    checkOutput("done_wins", '0, 2'd2, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, 8'd5);
    tick(1);
    checkOutput("done_wins_idle", '0, 2'd2, 1'b0, 1'b0);

    // Limit 0 disables timeout; raising it mid-grant applies immediately.
    c = cyc;
    applyStimulus(4'b0001, 1'b0, '0);
    expectGrant(0, c + 1);
    tick(1);
    g = cyc;
    applyStimulus('0, 1'b0, '0);
    tick(10);
    checkOutput("no_timeout_limit0", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, 8'd10);
    expectTmo(0, g + 11);
    tick(2);

    // done together with a request in IDLE must not block the grant.
    c = cyc;
    applyStimulus(4'b0010, 1'b1, '0);
    expectGrant(1, c + 1);
    tick(1);
    applyStimulus('0, 1'b1, '0);
    tick(1);
    applyStimulus('0, 1'b0, '0);
    checkOutput("done_in_idle_recover", '0, 2'd1, 1'b1, 1'b0);
    tick(1);

    // Arbitration table.
    for (int i = 0; i < 4; i++) begin
      c = cyc;
      applyStimulus(tbl_req[i], 1'b0, '0);
      expectGrant(tbl_exp[i], c + 1);
      tick(1);
      applyStimulus('0, 1'b1, '0);
      tick(1);
      applyStimulus('0, 1'b0, '0);
      tick(1);
    end

    // Counter saturates at all-ones, so limit 255 hits after a long grant.
    c = cyc;
    applyStimulus(4'b0001, 1'b0, '0);
    expectGrant(0, c + 1);
    tick(1);
    g = cyc;
    applyStimulus('0, 1'b0, '0);
    tick(260);
    checkOutput("saturate_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, 8'd255);
    expectTmo(0, g + 261);
    tick(2);

    // Asynchronous reset two cycles into a grant.
    c = cyc;
    applyStimulus(4'b0001, 1'b0, 8'd3);
    expectGrant(0, c + 1);
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", '0, '0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, '0);
    tick(2);
    checkOutput("held_in_reset", '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    c = cyc;
    expectGrant(2, c + 1);
    tick(1);
    checkOutput("post_reset_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus('0, 1'b1, '0);
    tick(1);
    applyStimulus('0, 1'b0, '0);
    tick(3);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending events, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
